conv3x3_stream_engine: RTL
==========================

Name: conv3x3_stream_engine

Overview:
Parametrised successor to the single-mode conv core. It performs a 3x3 2-D convolution over an IMG_HEIGHT x IMG_WIDTH image held in bram0, one pixel per 32-bit word, and writes results to bram1.
- The image is streamed once through two line buffers, at one input pixel per cycle.
- New behaviour: a runtime kernel port, a zero-pad ("same") or valid output mode, an arithmetic output shift, optional ReLU, and saturation.
- Sits between the AXI-lite control wrapper and the two BRAM ports, using the existing start/done handshake.

Parameters:
- IMG_WIDTH, 256, image columns (>=3).
- IMG_HEIGHT, 256, image rows (>=3).
- PIX_W, 8, unsigned pixel width, taken from bram0_dout[PIX_W-1:0].
- WGT_W, 8, signed kernel weight width.
- ACC_W, 20, signed accumulator width; must satisfy ACC_W >= PIX_W+WGT_W+4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse; sampled only in IDLE.
- pad_en  in  1  1 = same mode with zero padding (H x W outputs); 0 = valid mode ((H-2) x (W-2) outputs).
- relu_en  in  1  1 = clamp the result to [0, 2^PIX_W-1]; 0 = clamp to a signed PIX_W-bit range.
- shift  in  4  arithmetic right shift applied to the accumulator before clamping.
- kernel  in  9*WGT_W  weights; tap k = r*3+c occupies [k*WGT_W +: WGT_W].
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse at the end of a run.
- bram0_en  out  1  read enable.
- bram0_addr  out  32  byte address; word index in [17:2], bits [1:0] = 0.
- bram0_dout  in  32  read data, valid the cycle after bram0_en.
- bram1_we  out  4  byte write enable; 4'hF on a write, otherwise 0.
- bram1_addr  out  32  byte address.
- bram1_din  out  32  result, sign-extended from PIX_W+1 bits.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters cleared. Line buffer contents are don't-care. Reset mid-run aborts the run with no further writes and no done.
- start in IDLE: latch pad_en, relu_en, shift and kernel (they are stable for the whole run); go to RUN. start in any other state is ignored.
- RUN: the scan counters row 0..IMG_HEIGHT and col 0..IMG_WIDTH advance one position per cycle, col fastest.
  - When row<H and col<W: bram0_en=1 and bram0_addr=(row*W+col)<<2.
  - Otherwise bram0_en=0 and a zero pixel is injected (trailing pad row/column).
- Data path: each arriving pixel shifts into the 3x3 window and the line buffers.
  - The window at scan (r,c) is centred on output position (r-1, c-1).
  - Taps falling outside the image (row -1/H or col -1/W) are forced to 0, including column wrap from the previous row.
- Arithmetic:
  - Each tap product is unsigned pixel x signed weight; the nine products are summed at ACC_W.
  - The sum is then arithmetically right-shifted by shift.
  - relu_en=1: clamp to [0, 2^PIX_W-1]. relu_en=0: clamp to [-2^(PIX_W-1), 2^(PIX_W-1)-1].
  - The clamped value is sign-extended to 32 bits.
- Output emission:
  - Centre (i,j) with 0<=i<H, 0<=j<W.
  - pad_en=1: every centre is written, at word i*W+j.
  - pad_en=0: only centres with 1<=i<=H-2 and 1<=j<=W-2 are written, at word (i-1)*(W-2)+(j-1).
  - Writes occur in raster order, one per cycle at most.
- Latency: fixed 3 cycles from bram0 data arrival to the bram1_we cycle (window register, MAC register, clamp register).
- DRAIN: entered after the last scan position; waits for the pipeline to empty.
- DONE: done=1 for exactly one cycle, on the cycle after the final write; busy drops in the same cycle; then return to IDLE.
- Cycle budget: done within (H+1)*(W+1)+6 cycles of start.

Decomposition:
- conv_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE), the tap-index constants, and a clamp function parametrised by PIX_W and ACC_W.
- One sub-module, conv_line_buffer: two IMG_WIDTH-deep PIX_W-bit row FIFOs plus the 3x3 window registers, with a shift-enable input.

Test Plan:
- Run with IMG 8x8, pad_en=1, identity kernel (centre=1, rest 0), shift=0, relu_en=1, ramp image p=r*8+c -> bram1[k]=k for k=0..63; done within 87 cycles.
- All-ones kernel on a constant-10 image, pad_en=1, shift=0 -> corners 40, edges 60, interior 90.
- Same stimulus with pad_en=0 -> 36 words, all 90, at words 0..35; word 36 unchanged from its preload.
- Centre=-1 kernel on a constant-5 image: relu_en=1 -> all 0; relu_en=0 -> all 32'hFFFF_FFFB.
- Saturation and shift:
  - Centre=2 on a constant-200 image with relu_en=0 -> 32'h0000_007F; with relu_en=1 -> 32'h0000_00FF.
  - All-ones kernel on constant 200 with shift=4 -> interior 112.
- Control robustness:
  - A second start pulse while busy is ignored: exactly one done pulse.
  - rst asserted mid-RUN -> bram1_we=0 from the next cycle, no done.
  - A new start after the reset completes normally.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 streaming convolution engine:
// run-control states, window tap numbering and the output clamp.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Tap k = row*3 + col, row 0 is the oldest (top) line, col 0 the oldest (left) column.
   localparam int TAP_TL   = 0;
   localparam int TAP_TC   = 1;
   localparam int TAP_TR   = 2;
   localparam int TAP_ML   = 3;
   localparam int TAP_MC   = 4;
   localparam int TAP_MR   = 5;
   localparam int TAP_BL   = 6;
   localparam int TAP_BC   = 7;
   localparam int TAP_BR   = 8;
   localparam int NUM_TAPS = 9;

   // raw holds an acc_w-bit two's complement value in its low bits; the result is the
   // value clamped to the unsigned or signed pix_w-bit range, sign-extended to 32 bits.
   function automatic logic [31:0] clamp_pix(input logic [63:0] raw, input int acc_w,
                                             input int pix_w, input logic relu);
      logic signed [63:0] val;
      logic signed [63:0] lo;
      logic signed [63:0] hi;
      logic signed [63:0] res;
      val = $signed(raw << (64 - acc_w)) >>> (64 - acc_w);
      if (relu) begin
         lo = '0;
         hi = (64'sd1 <<< pix_w) - 64'sd1;
      end else begin
         hi = (64'sd1 <<< (pix_w - 1)) - 64'sd1;
         lo = -hi - 64'sd1;
      end
      if (val < lo) begin
         res = lo;
      end else if (val > hi) begin
         res = hi;
      end else begin
         res = val;
      end
      return res[31:0];
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two one-row pixel delay lines plus the 3x3 window registers. The window shifts on
// shift_en; the delay lines advance only for real image columns (col_en).
module conv_line_buffer #(
   parameter int IMG_WIDTH = 256,
   parameter int PIX_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 shift_en,
   input  logic                 col_en,
   input  logic [PIX_W-1:0]     pix_in,
   output logic [9*PIX_W-1:0]   win_out
);

   localparam int AW = $clog2(IMG_WIDTH);
   localparam logic [AW-1:0] PTR_LAST = AW'(IMG_WIDTH - 1);

   logic [PIX_W-1:0] row0_mem [IMG_WIDTH];
   logic [PIX_W-1:0] row1_mem [IMG_WIDTH];
   logic [PIX_W-1:0] rd0_q;
   logic [PIX_W-1:0] rd1_q;
   logic [AW-1:0]    ptr_q;
   logic [AW-1:0]    ptr_d;
   logic [AW-1:0]    ptr_nxt;
   logic             lb_shift;
   logic [PIX_W-1:0] col_new [3];

   assign lb_shift = shift_en && col_en;
   assign ptr_nxt  = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);

   always_comb begin
      ptr_d = ptr_q;
      if (lb_shift) begin
         ptr_d = ptr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Registered read pre-fetches the slot the next shift will consume; it never
   // collides with the slot being written because the width is at least 3.
   always_ff @(posedge clk) begin
      if (lb_shift) begin
         row0_mem[ptr_q] <= pix_in;
         row1_mem[ptr_q] <= rd0_q;
         rd0_q           <= row0_mem[ptr_nxt];
         rd1_q           <= row1_mem[ptr_nxt];
      end
   end

   always_comb begin
      col_new[0] = col_en ? rd1_q  : '0;
      col_new[1] = col_en ? rd0_q  : '0;
      col_new[2] = col_en ? pix_in : '0;
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      logic [PIX_W-1:0] tap_q [3];
      logic [PIX_W-1:0] tap_d [3];

      always_comb begin
         tap_d = tap_q;
         if (shift_en) begin
            tap_d[0] = tap_q[1];
            tap_d[1] = tap_q[2];
            tap_d[2] = col_new[gi];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            tap_q <= '{default: '0};
         end else begin
            tap_q <= tap_d;
         end
      end

      for (genvar gj = 0; gj < 3; gj++) begin : g_col
         assign win_out[(gi*3 + gj)*PIX_W +: PIX_W] = tap_q[gj];
      end
   end

endmodule

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution: raster-reads bram0 once, writes clamped results to bram1
// in raster order with optional zero padding, shift, ReLU and saturation.
module conv3x3_stream_engine
   import conv_pkg::*;
#(
   parameter int IMG_WIDTH  = 256,
   parameter int IMG_HEIGHT = 256,
   parameter int PIX_W      = 8,
   parameter int WGT_W      = 8,
   parameter int ACC_W      = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 pad_en,
   input  logic                 relu_en,
   input  logic [3:0]           shift,
   input  logic [9*WGT_W-1:0]   kernel,
   output logic                 busy,
   output logic                 done,
   output logic                 bram0_en,
   output logic [31:0]          bram0_addr,
   input  logic [31:0]          bram0_dout,
   output logic [3:0]           bram1_we,
   output logic [31:0]          bram1_addr,
   output logic [31:0]          bram1_din
);

   localparam int RW = $clog2(IMG_HEIGHT + 1);
   localparam int CW = $clog2(IMG_WIDTH + 1);
   localparam int PW = PIX_W + 1 + WGT_W;
   localparam logic [RW-1:0] ROW_END  = RW'(IMG_HEIGHT);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [CW-1:0] COL_END  = CW'(IMG_WIDTH);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);

   state_t               state_q, state_d;
   logic [RW-1:0]        row_q, row_d;
   logic [CW-1:0]        col_q, col_d;
   logic [29:0]          rd_idx_q, rd_idx_d;
   logic [29:0]          wr_idx_q, wr_idx_d;
   logic                 pad_q, pad_d;
   logic                 relu_q, relu_d;
   logic [3:0]           shift_q, shift_d;
   logic [9*WGT_W-1:0]   kernel_q, kernel_d;
   logic                 a_vld_q, a_vld_d;
   logic                 a_real_q, a_real_d;
   logic [RW-1:0]        a_row_q, a_row_d;
   logic [CW-1:0]        a_col_q, a_col_d;
   logic                 w_vld_q, w_vld_d;
   logic [RW-1:0]        w_row_q, w_row_d;
   logic [CW-1:0]        w_col_q, w_col_d;
   logic                 m_emit_q, m_emit_d;
   logic signed [ACC_W-1:0] m_acc_q, m_acc_d;
   logic                 we_q, we_d;
   logic [31:0]          din_q, din_d;
   logic [29:0]          waddr_q, waddr_d;

   logic                 scan_real;
   logic                 emit_ok;
   logic                 pipe_empty;
   logic [PIX_W-1:0]     pix_in;
   logic [9*PIX_W-1:0]   win;
   logic signed [PW-1:0] prod [NUM_TAPS];
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] acc_shifted;
   logic                 unused_dout;

   assign scan_real   = (row_q < ROW_END) && (col_q < COL_END);
   assign pix_in      = a_real_q ? bram0_dout[PIX_W-1:0] : '0;
   assign unused_dout = ^bram0_dout[31:PIX_W];
   assign pipe_empty  = !a_vld_q && !w_vld_q && !m_emit_q;

   conv_line_buffer #(
      .IMG_WIDTH (IMG_WIDTH),
      .PIX_W     (PIX_W)
   ) u_line_buffer (
      .clk      (clk),
      .rst      (rst),
      .shift_en (a_vld_q),
      .col_en   (a_vld_q && (a_col_q != COL_END)),
      .pix_in   (pix_in),
      .win_out  (win)
   );

   // Window at scan (r,c) is centred on (r-1,c-1): its top row is outside the image for
   // r<2 and its left column is outside (or wrapped from the previous row) for c<2.
   for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      logic                 kill;
      logic signed [PW-1:0] px_ext;
      logic signed [PW-1:0] wt_ext;
      assign kill     = ((gi <= TAP_TR) && (w_row_q < ROW_TWO)) ||
                        (((gi % 3) == TAP_TL) && (w_col_q < COL_TWO));
      assign px_ext   = PW'($signed({1'b0, win[gi*PIX_W +: PIX_W]}));
      assign wt_ext   = PW'($signed(kernel_q[gi*WGT_W +: WGT_W]));
      assign prod[gi] = kill ? '0 : px_ext * wt_ext;
   end

   always_comb begin
      acc_sum = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         acc_sum = acc_sum + ACC_W'(prod[k]);
      end
   end

   always_comb begin
      if (pad_q) begin
         emit_ok = (w_row_q >= ROW_ONE) && (w_col_q >= COL_ONE);
      end else begin
         emit_ok = (w_row_q >= ROW_TWO) && (w_row_q <= ROW_LAST) &&
                   (w_col_q >= COL_TWO) && (w_col_q <= COL_LAST);
      end
   end

   assign acc_shifted = m_acc_q >>> shift_q;

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      rd_idx_d = rd_idx_q;
      wr_idx_d = wr_idx_q + 30'(m_emit_q);
      pad_d    = pad_q;
      relu_d   = relu_q;
      shift_d  = shift_q;
      kernel_d = kernel_q;

      a_vld_d  = (state_q == RUN);
      a_real_d = (state_q == RUN) && scan_real;
      a_row_d  = row_q;
      a_col_d  = col_q;
      w_vld_d  = a_vld_q;
      w_row_d  = a_row_q;
      w_col_d  = a_col_q;
      m_emit_d = w_vld_q && emit_ok;
      m_acc_d  = acc_sum;
      we_d     = m_emit_q;
      din_d    = clamp_pix({{(64-ACC_W){1'b0}}, acc_shifted}, ACC_W, PIX_W, relu_q);
      waddr_d  = wr_idx_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               pad_d    = pad_en;
               relu_d   = relu_en;
               shift_d  = shift;
               kernel_d = kernel;
               row_d    = '0;
               col_d    = '0;
               rd_idx_d = '0;
               wr_idx_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (scan_real) begin
               rd_idx_d = rd_idx_q + 30'd1;
            end
            if (col_q == COL_END) begin
               col_d = '0;
               if (row_q == ROW_END) begin
                  state_d = DRAIN;
               end else begin
                  row_d = row_q + ROW_ONE;
               end
            end else begin
               col_d = col_q + COL_ONE;
            end
         end
         DRAIN: begin
            // The last write may still be on the bram1 port this cycle; done follows it.
            if (pipe_empty) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         row_q    <= '0;
         col_q    <= '0;
         rd_idx_q <= '0;
         wr_idx_q <= '0;
         pad_q    <= 1'b0;
         relu_q   <= 1'b0;
         shift_q  <= '0;
         kernel_q <= '0;
         a_vld_q  <= 1'b0;
         a_real_q <= 1'b0;
         a_row_q  <= '0;
         a_col_q  <= '0;
         w_vld_q  <= 1'b0;
         w_row_q  <= '0;
         w_col_q  <= '0;
         m_emit_q <= 1'b0;
         m_acc_q  <= '0;
         we_q     <= 1'b0;
         din_q    <= '0;
         waddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         rd_idx_q <= rd_idx_d;
         wr_idx_q <= wr_idx_d;
         pad_q    <= pad_d;
         relu_q   <= relu_d;
         shift_q  <= shift_d;
         kernel_q <= kernel_d;
         a_vld_q  <= a_vld_d;
         a_real_q <= a_real_d;
         a_row_q  <= a_row_d;
         a_col_q  <= a_col_d;
         w_vld_q  <= w_vld_d;
         w_row_q  <= w_row_d;
         w_col_q  <= w_col_d;
         m_emit_q <= m_emit_d;
         m_acc_q  <= m_acc_d;
         we_q     <= we_d;
         din_q    <= din_d;
         waddr_q  <= waddr_d;
      end
   end

   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign done       = (state_q == DONE);
   assign bram0_en   = (state_q == RUN) && scan_real;
   assign bram0_addr = bram0_en ? {rd_idx_q, 2'b00} : '0;
   assign bram1_we   = {4{we_q}};
   assign bram1_addr = {waddr_q, 2'b00};
   assign bram1_din  = din_q;

endmodule
